// File: rtl/hc_pkg.sv
// Shared types and defaults for the host-channel stream blocks.
// Holds the sequencer state encoding and its default chunk size.
package hc_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DRAIN,
    SEQ_DONE
  } t_seq_state;

  localparam int SEQ_CHUNK_DEFAULT = 8;
  localparam int SEQ_DEPTH_DEFAULT = 30;
  localparam int SEQ_COUNT_W_DEFAULT = 32;

endpackage

// File: rtl/seq_credit_counter.sv
// Credit register for the downstream FIFO: take(n) on issue, give(1) on write.
// A give that would push credits above DEPTH is dropped and flagged.
import hc_pkg::*;

module seq_credit_counter #(
  parameter int W     = SEQ_COUNT_W_DEFAULT,
  parameter int DEPTH = SEQ_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         take,
  input  logic [W-1:0] take_n,
  input  logic         give,
  output logic [W-1:0] credits,
  output logic         overflow
);

  localparam logic [W-1:0] FULL = W'(DEPTH);
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  assign overflow = give && !take && (credits == FULL);

  // credit update: same-cycle take and give net to credits - n + 1
  always_ff @(posedge clk) begin
    if (reset || init) begin
      credits <= FULL;
    end else if (take && give) begin
      credits <= credits - take_n + ONE;
    end else if (take) begin
      credits <= credits - take_n;
    end else if (give && !overflow) begin
      credits <= credits + ONE;
    end
  end

endmodule

// File: rtl/stream_sequencer.sv
// Read->FIFO->write transfer sequencer with chunked, credit-limited requests.
// Define STREAM_SEQ_STATS_EN to add stall_cycles/xfer_cycles outputs.
import hc_pkg::*;

module stream_sequencer #(
  parameter int COUNT_W     = SEQ_COUNT_W_DEFAULT,
  parameter int CHUNK_LINES = SEQ_CHUNK_DEFAULT,
  parameter int FIFO_DEPTH  = SEQ_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_lines,
  output logic               rd_req_en,
  output logic [COUNT_W-1:0] rd_req_size,
  input  logic               rd_rsp_valid,
  input  logic               wr_done,
  output logic               busy,
  output logic               finish,
  output logic               err
`ifdef STREAM_SEQ_STATS_EN
  ,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] xfer_cycles
`endif
);

  localparam logic [COUNT_W-1:0] CHUNK = COUNT_W'(CHUNK_LINES);
  localparam logic [COUNT_W-1:0] ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};

  t_seq_state         state_q;
  t_seq_state         state_d;
  logic [COUNT_W-1:0] total_q;
  logic [COUNT_W-1:0] remaining_q;
  logic [COUNT_W-1:0] rcvd_q;
  logic [COUNT_W-1:0] written_q;
  logic [COUNT_W-1:0] issued;
  logic [COUNT_W-1:0] credits;
  logic [COUNT_W-1:0] chunk;
  logic               take;
  logic               start_ok;
  logic               rsp_ok;
  logic               wr_ok;
  logic               overflow;

  assign busy     = (state_q == SEQ_ISSUE) || (state_q == SEQ_DRAIN);
  assign start_ok = start && !busy;
  assign issued   = total_q - remaining_q;
  assign rsp_ok   = rd_rsp_valid && busy && (rcvd_q < issued);
  assign wr_ok    = wr_done && busy && (written_q < rcvd_q);
  assign take     = (state_q == SEQ_ISSUE) && (chunk != '0);

  seq_credit_counter #(
    .W     (COUNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .init     (start_ok),
    .take     (take),
    .take_n   (chunk),
    .give     (wr_ok),
    .credits  (credits),
    .overflow (overflow)
  );

  // chunk = min(CHUNK_LINES, remaining, credits)
  always_comb begin
    chunk = CHUNK;
    if (remaining_q < chunk) chunk = remaining_q;
    if (credits < chunk) chunk = credits;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (start)
          state_d = (num_lines == '0) ? SEQ_DONE : SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        if (take && (remaining_q == chunk))
          state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (wr_ok && ((written_q + ONE) == total_q))
          state_d = SEQ_DONE;
      end
    endcase
  end

  // state, counters, request pulse and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      total_q     <= '0;
      remaining_q <= '0;
      rcvd_q      <= '0;
      written_q   <= '0;
      rd_req_en   <= 1'b0;
      rd_req_size <= '0;
      finish      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_req_en   <= take;
      rd_req_size <= take ? chunk : '0;
      finish      <= (state_q == SEQ_DONE) && !start_ok;
      if (start_ok) begin
        total_q     <= num_lines;
        remaining_q <= num_lines;
        rcvd_q      <= '0;
        written_q   <= '0;
        err         <= 1'b0;
      end else begin
        if (take) remaining_q <= remaining_q - chunk;
        if (rsp_ok) rcvd_q <= rcvd_q + ONE;
        if (wr_ok) written_q <= written_q + ONE;
        if ((rd_rsp_valid && !rsp_ok) || (wr_done && !wr_ok) || overflow)
          err <= 1'b1;
      end
    end
  end

`ifdef STREAM_SEQ_STATS_EN
  // starvation and busy-time counters, frozen outside a transfer
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stall_cycles <= '0;
      xfer_cycles  <= '0;
    end else begin
      if ((state_q == SEQ_ISSUE) && (credits == '0))
        stall_cycles <= stall_cycles + ONE;
      if (busy)
        xfer_cycles <= xfer_cycles + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_stream_sequencer.sv
// Directed bench for stream_sequencer: two instances, FIFO depth 30 and 16.
// Expected sizes and cycle numbers are hand-derived per scenario.
module tb_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  bit          sel;
  logic [31:0] num_lines;
  logic        rd_rsp_valid;
  logic        wr_done;

  logic        en_a, en_b, busy_a, busy_b, fin_a, fin_b, err_a, err_b;
  logic [31:0] size_a, size_b;
`ifdef STREAM_SEQ_STATS_EN
  logic [31:0] stall_a, xfer_a, stall_b, xfer_b;
`endif

  logic        en_s, busy_s, fin_s, err_s;
  logic [31:0] size_s;

  int n_cmp = 0;
  int n_bad = 0;
  int sz_q[$];
  int cyc_q[$];
  int fin_cyc;
  int busy_cnt;
  int sum;

  always #5 clk = ~clk;

  assign en_s   = sel ? en_b : en_a;
  assign size_s = sel ? size_b : size_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign fin_s  = sel ? fin_b : fin_a;
  assign err_s  = sel ? err_b : err_a;

  stream_sequencer #(
    .COUNT_W (32), .CHUNK_LINES (8), .FIFO_DEPTH (30)
  ) u_a (
    .clk          (clk),
    .reset        (reset),
    .start        (go && !sel),
    .num_lines    (num_lines),
    .rd_req_en    (en_a),
    .rd_req_size  (size_a),
    .rd_rsp_valid (rd_rsp_valid),
    .wr_done      (wr_done),
    .busy         (busy_a),
    .finish       (fin_a),
    .err          (err_a)
`ifdef STREAM_SEQ_STATS_EN
    ,
    .stall_cycles (stall_a),
    .xfer_cycles  (xfer_a)
`endif
  );

  stream_sequencer #(
    .COUNT_W (32), .CHUNK_LINES (8), .FIFO_DEPTH (16)
  ) u_b (
    .clk          (clk),
    .reset        (reset),
    .start        (go && sel),
    .num_lines    (num_lines),
    .rd_req_en    (en_b),
    .rd_req_size  (size_b),
    .rd_rsp_valid (rd_rsp_valid),
    .wr_done      (wr_done),
    .busy         (busy_b),
    .finish       (fin_b),
    .err          (err_b)
`ifdef STREAM_SEQ_STATS_EN
    ,
    .stall_cycles (stall_b),
    .xfer_cycles  (xfer_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer on the selected DUT and act as read/write agent.
  // Start is sampled at edge 0; sample c is taken just after edge c.
  task automatic run_xfer(input int n, input int lag, input int hold,
                          input int extra);
    int pend, sent, wsent, xleft, e2;
    int rcum[0:511];
    bit r, w;
    sz_q.delete();
    cyc_q.delete();
    fin_cyc = -1;
    busy_cnt = 0;
    pend = 0;
    sent = 0;
    wsent = 0;
    xleft = extra;
    e2 = -1;
    foreach (rcum[i]) rcum[i] = 0;
    num_lines = n;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int c = 0; c < 500 && fin_cyc < 0; c++) begin
      if (busy_s) busy_cnt++;
      if (en_s) begin
        sz_q.push_back(int'(size_s));
        cyc_q.push_back(c);
        pend += int'(size_s);
        if (sz_q.size() == 2) e2 = c;
      end
      if (fin_s) fin_cyc = c;
      r = 1'b0;
      if (pend > 0) begin
        r = 1'b1;
        pend--;
        sent++;
      end else if (sent == n && xleft > 0) begin
        r = 1'b1;
        xleft--;
      end
      rcum[c+1] = sent;
      w = 1'b0;
      if (wsent < n && c + 1 - lag >= 0 && wsent < rcum[c+1-lag] &&
          (hold == 0 || (e2 >= 0 && c + 1 >= e2 + hold))) begin
        w = 1'b1;
        wsent++;
      end
      rd_rsp_valid = r;
      wr_done = w;
      if (fin_cyc < 0) step();
    end
    rd_rsp_valid = 1'b0;
    wr_done = 1'b0;
    check("finish_seen", (fin_cyc >= 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    go = 1'b0;
    sel = 1'b0;
    num_lines = '0;
    rd_rsp_valid = 1'b0;
    wr_done = 1'b0;
    step();
    step();
    check("rst_en", en_a, 0);
    check("rst_size", size_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fin", fin_a, 0);
    check("rst_err", err_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    step();

    // 30 lines, depth 30, write 2 cycles after each response
    run_xfer(30, 2, 0, 0);
    check("t1_npulse", sz_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      int exp_sz[4] = '{8, 8, 8, 6};
      if (i < sz_q.size()) check($sformatf("t1_size%0d", i), sz_q[i], exp_sz[i]);
    end
    if (cyc_q.size() > 0) check("t1_latency", cyc_q[0], 1);
    check("t1_fin_cyc", fin_cyc, 34);
    check("t1_err", err_a, 0);
    check("t1_busy_done", busy_a, 0);

    // same transfer plus one response beyond the issued count
    run_xfer(30, 2, 0, 1);
    check("t5_fin_cyc", fin_cyc, 34);
    check("t5_err", err_a, 1);
    step();
    check("t5_err_sticky", err_a, 1);
    check("t5_fin_held", fin_a, 1);

    // zero-length transfer
    num_lines = 0;
    go = 1'b1;
    step();
    go = 1'b0;
    check("t3_fin_n", fin_a, 0);
    check("t3_busy_n", busy_a, 0);
    check("t3_err", err_a, 0);
    step();
    check("t3_fin_n1", fin_a, 1);
    check("t3_busy_n1", busy_a, 0);
    check("t3_en", en_a, 0);
    step();
    check("t3_fin_hold", fin_a, 1);

    // reset in DRAIN with 10 lines outstanding
    num_lines = 10;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    check("t4_size0", size_a, 8);
    step();
    check("t4_size1", size_a, 2);
    check("t4_busy", busy_a, 1);
    num_lines = 5;
    go = 1'b1;
    wr_done = 1'b1;
    step();
    go = 1'b0;
    wr_done = 1'b0;
    check("t4_start_ign", busy_a, 1);
    check("t4_no_pulse", en_a, 0);
    check("t4_err_set", err_a, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_rst_en", en_a, 0);
    check("t4_rst_size", size_a, 0);
    check("t4_rst_busy", busy_a, 0);
    check("t4_rst_fin", fin_a, 0);
    check("t4_rst_err", err_a, 0);
    run_xfer(3, 2, 0, 0);
    check("t4_npulse", sz_q.size(), 1);
    if (sz_q.size() > 0) check("t4_size", sz_q[0], 3);
    check("t4_fin_cyc", fin_cyc, 7);

    // depth 16: 8,8 then 5-cycle starvation, then size-1 refills
    sel = 1'b1;
    run_xfer(30, 1, 5, 0);
    check("t2_npulse", sz_q.size(), 16);
    if (sz_q.size() >= 3) begin
      check("t2_size0", sz_q[0], 8);
      check("t2_size1", sz_q[1], 8);
      check("t2_size2", sz_q[2], 1);
      check("t2_stall_gap", cyc_q[2], 8);
    end
    sum = 0;
    foreach (sz_q[i]) sum += sz_q[i];
    check("t2_sum", sum, 30);
    check("t2_fin_cyc", fin_cyc, 37);
    check("t2_err", err_b, 0);
`ifdef STREAM_SEQ_STATS_EN
    check("t6_stall", stall_b, 5);
    check("t6_xfer_busy", xfer_b, busy_cnt);
    check("t6_xfer", xfer_b, 36);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
